// File: rtl/serial_alu_v2.sv
// serial_alu_v2: serial-command ALU with 8 ops including an iterative shift-add multiply
//   clk          in   clock, rising edge
//   reset_n      in   synchronous active-low reset
//   opcode_valid in   high for the 3 command cycles
//   opcode       in   serial opcode bit op[0], op[1], op[2]
//   data         in   operand A (cycle 1), operand B (cycle 2)
//   result       out  registered result, held until next completion
//   overflow     out  registered overflow, updates with result
//   done         out  one-cycle completion pulse
//   busy         out  high while executing (EXEC, MUL, DONE)
//   op_count     out  completed-operation count, wraps
module serial_alu_v2 #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 opcode_valid,
    input  logic                 opcode,
    input  logic [WIDTH-1:0]     data,
    output logic [WIDTH-1:0]     result,
    output logic                 overflow,
    output logic                 done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] op_count
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [2:0] {IDLE, GET_B, GET_OP, EXEC, MUL, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, alu_res;
    logic [2:0] op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] op_count_q, op_count_d;
    logic [WIDTH:0] sum;
    logic overflow_q, overflow_d, done_q, done_d, alu_ov;
    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = '0;
        alu_ov  = 1'b0;
        case (op_q)
            3'd0: begin alu_res = sum[WIDTH-1:0]; alu_ov = sum[WIDTH]; end
            3'd1: begin alu_res = a_q - b_q; alu_ov = a_q < b_q; end
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: alu_res = WIDTH'({a_q > b_q, a_q == b_q});
            3'd6: alu_res = WIDTH'((^a_q) ^ (^b_q));
            default: alu_res = '0;
        endcase
    end
    // b_q doubles as the multiplier, consumed LSB first while the multiplicand shifts left
    assign acc_next = acc_q + (b_q[0] ? mcand_q : '0);
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        op_count_d = op_count_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (opcode_valid) begin
                a_d     = data;
                op_d    = {2'b00, opcode};
                state_d = GET_B;
            end
            GET_B: begin
                b_d     = data;
                op_d[1] = opcode;
                state_d = opcode_valid ? GET_OP : IDLE;
            end
            GET_OP: begin
                op_d[2] = opcode;
                state_d = opcode_valid ? EXEC : IDLE;
            end
            EXEC: if (op_q == 3'd7) begin
                acc_d   = '0;
                mcand_d = {{WIDTH{1'b0}}, a_q};
                cnt_d   = CW'(WIDTH);
                state_d = MUL;
            end else begin
                result_d   = alu_res;
                overflow_d = alu_ov;
                done_d     = 1'b1;
                state_d    = DONE;
            end
            MUL: begin
                acc_d   = acc_next;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d   = acc_next[WIDTH-1:0];
                    overflow_d = |acc_next[2*WIDTH-1:WIDTH];
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                op_count_d = op_count_q + CNT_WIDTH'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            op_count_q <= op_count_d;
        end
    end
    assign result   = result_q;
    assign overflow = overflow_q;
    assign done     = done_q;
    assign busy     = state_q inside {EXEC, MUL, DONE};
    assign op_count = op_count_q;
endmodule
